// File: rtl/jac_pkg.sv
// Shared definitions for the Jac1-8 fetch path.
// Holds default widths and the fetch state encoding.
package jac_pkg;

  localparam int unsigned JAC_PC_WIDTH     = 8;
  localparam int unsigned JAC_RESET_VECTOR = 0;

  typedef enum logic {
    RUN  = 1'b0,
    HALT = 1'b1
  } fetch_state_e;

endpackage

// File: rtl/pc_fetch_unit_return_stack.sv
// Small LIFO of return addresses.
// Push when full and pop when empty are ignored.
module return_stack #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     res,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam logic [CW-1:0] C_ONE = CW'(1);
  localparam logic [AW-1:0] A_ONE = AW'(1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [CW-1:0]    count_q, count_d;
  logic [AW-1:0]    wr_idx, rd_idx;

  assign wr_idx = count_q[AW-1:0];
  assign rd_idx = wr_idx - A_ONE;
  assign full   = (count_q == CW'(DEPTH));
  assign empty  = (count_q == '0);
  assign dout   = mem[rd_idx];
  assign count  = count_q;

  always_comb begin
    count_d = count_q;
    if (push && !full) begin
      count_d = count_q + C_ONE;
    end else if (pop && !empty) begin
      count_d = count_q - C_ONE;
    end
  end

  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  // Entry contents need no reset; only occupancy matters.
  always_ff @(posedge clk) begin
    if (push && !full) begin
      mem[wr_idx] <= din;
    end
  end

endmodule

// File: rtl/pc_fetch_unit.sv
// Program counter and fetch sequencer with a hardware return stack.
// Overflow or underflow of the stack parks the unit in HALT until reset.
module pc_fetch_unit
  import jac_pkg::*;
#(
  parameter int unsigned PC_WIDTH     = JAC_PC_WIDTH,
  parameter int unsigned STACK_DEPTH  = 4,
  parameter int unsigned RESET_VECTOR = JAC_RESET_VECTOR
) (
  input  logic                           clk,
  input  logic                           res,
  input  logic                           stall,
  input  logic                           jmp_en,
  input  logic                           call_en,
  input  logic                           ret_en,
  input  logic [PC_WIDTH-1:0]            jmp_addr,
  output logic [PC_WIDTH-1:0]            pc,
  output logic [$clog2(STACK_DEPTH):0]   sp,
  output logic                           halted,
  output logic                           stack_ovf,
  output logic                           stack_unf
);

  localparam logic [PC_WIDTH-1:0] PC_ONE = PC_WIDTH'(1);

  fetch_state_e          state_q, state_d;
  logic [PC_WIDTH-1:0]   pc_q, pc_d, pc_inc, ras_top;
  logic                  ovf_q, ovf_d, unf_q, unf_d;
  logic                  push, pop, full, empty;

  assign pc_inc = pc_q + PC_ONE;

  return_stack #(
    .WIDTH(PC_WIDTH),
    .DEPTH(STACK_DEPTH)
  ) u_ras (
    .clk  (clk),
    .res  (res),
    .push (push),
    .pop  (pop),
    .din  (pc_inc),
    .dout (ras_top),
    .count(sp),
    .full (full),
    .empty(empty)
  );

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ovf_d   = ovf_q;
    unf_d   = unf_q;
    push    = 1'b0;
    pop     = 1'b0;
    if (state_q == RUN && !stall) begin
      if (ret_en) begin
        if (!empty) begin
          pc_d = ras_top;
          pop  = 1'b1;
        end else begin
          unf_d   = 1'b1;
          state_d = HALT;
        end
      end else if (call_en) begin
        if (!full) begin
          pc_d = jmp_addr;
          push = 1'b1;
        end else begin
          ovf_d   = 1'b1;
          state_d = HALT;
        end
      end else if (jmp_en) begin
        pc_d = jmp_addr;
      end else begin
        pc_d = pc_inc;
      end
    end
  end

  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      state_q <= RUN;
      pc_q    <= PC_WIDTH'(RESET_VECTOR);
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  assign pc        = pc_q;
  assign halted    = (state_q == HALT);
  assign stack_ovf = ovf_q;
  assign stack_unf = unf_q;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Bench for pc_fetch_unit: directed scenarios plus random traffic
// against a queue-based model of the fetch sequencer.
module tb_pc_fetch_unit;

  logic       clk = 1'b0;
  logic       res = 1'b1;
  logic       stall = 1'b0;
  logic       jmp_en = 1'b0;
  logic       call_en = 1'b0;
  logic       ret_en = 1'b0;
  logic [7:0] jmp_addr = '0;
  logic [7:0] pc;
  logic [2:0] sp;
  logic       halted, stack_ovf, stack_unf;

  int checks = 0;
  int errors = 0;
  bit cmp_en = 1'b0;

  int unsigned m_pc = 0;
  int unsigned m_stk[$];
  bit m_halt = 0, m_ovf = 0, m_unf = 0;

  pc_fetch_unit #(
    .PC_WIDTH(8),
    .STACK_DEPTH(4),
    .RESET_VECTOR(0)
  ) dut (
    .clk      (clk),
    .res      (res),
    .stall    (stall),
    .jmp_en   (jmp_en),
    .call_en  (call_en),
    .ret_en   (ret_en),
    .jmp_addr (jmp_addr),
    .pc       (pc),
    .sp       (sp),
    .halted   (halted),
    .stack_ovf(stack_ovf),
    .stack_unf(stack_unf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pc = 0;
    m_stk.delete();
    m_halt = 0;
    m_ovf = 0;
    m_unf = 0;
  endtask

  // Fetch rules applied with plain arithmetic on the sampled inputs.
  task automatic model_step(input bit s, input bit j, input bit c,
                            input bit r, input int unsigned a);
    if (m_halt || s) return;
    if (r) begin
      if (m_stk.size() > 0) m_pc = m_stk.pop_back();
      else begin m_unf = 1; m_halt = 1; end
    end else if (c) begin
      if (m_stk.size() < 4) begin
        m_stk.push_back((m_pc + 1) % 256);
        m_pc = a;
      end else begin m_ovf = 1; m_halt = 1; end
    end else if (j) begin
      m_pc = a;
    end else begin
      m_pc = (m_pc + 1) % 256;
    end
  endtask

  always @(negedge clk) begin
    if (cmp_en && !res) begin
      chk("pc", int'(pc), int'(m_pc));
      chk("sp", int'(sp), m_stk.size());
      chk("halted", int'(halted), int'(m_halt));
      chk("stack_ovf", int'(stack_ovf), int'(m_ovf));
      chk("stack_unf", int'(stack_unf), int'(m_unf));
    end
  end

  task automatic cyc(input bit s, input bit j, input bit c,
                     input bit r, input logic [7:0] a);
    stall = s; jmp_en = j; call_en = c; ret_en = r; jmp_addr = a;
    @(posedge clk);
    model_step(s, j, c, r, int'(a));
    @(negedge clk);
  endtask

  task automatic free(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 8'h00);
  endtask

  task automatic do_reset();
    cmp_en = 1'b0;
    stall = 0; jmp_en = 0; call_en = 0; ret_en = 0;
    res = 1'b1;
    model_reset();
    @(posedge clk);
    @(negedge clk);
    res = 1'b0;
    cmp_en = 1'b1;
  endtask

  initial begin
    @(negedge clk);
    do_reset();
    chk("rst_pc", int'(pc), 0);
    chk("rst_flags", int'({halted, stack_ovf, stack_unf, sp}), 0);

    free(4);
    chk("free4_pc", int'(pc), 4);
    free(1);
    cyc(0, 1, 0, 0, 8'h1C);
    chk("jmp_pc", int'(pc), 'h1C);
    free(1);
    chk("jmp_next", int'(pc), 'h1D);
    chk("model_jmp", int'(m_pc), 'h1D);
    cyc(0, 1, 0, 0, 8'h06);
    repeat (3) cyc(1, 1, 1, 0, 8'h99);
    chk("stall_pc", int'(pc), 6);
    free(1);
    chk("stall_resume", int'(pc), 7);

    cyc(0, 1, 0, 0, 8'h0A);
    cyc(0, 0, 1, 0, 8'h20);
    chk("call_pc", int'(pc), 'h20);
    chk("call_sp", int'(sp), 1);
    cyc(0, 0, 0, 1, 8'h00);
    chk("ret_pc", int'(pc), 'h0B);
    chk("ret_sp", int'(sp), 0);
    cyc(0, 0, 1, 0, 8'h30);
    cyc(0, 0, 1, 0, 8'h40);
    cyc(0, 0, 1, 0, 8'h50);
    cyc(0, 0, 1, 0, 8'h60);
    chk("nest_sp", int'(sp), 4);
    cyc(0, 0, 0, 1, 8'h00);
    chk("lifo1", int'(pc), 'h51);
    cyc(0, 0, 0, 1, 8'h00);
    chk("lifo2", int'(pc), 'h41);
    cyc(0, 0, 0, 1, 8'h00);
    chk("lifo3", int'(pc), 'h31);
    cyc(0, 0, 0, 1, 8'h00);
    chk("lifo4", int'(pc), 'h0C);
    chk("model_lifo", int'(m_pc), 'h0C);

    for (int i = 0; i < 4; i++) cyc(0, 0, 1, 0, 8'h80 + 8'(i));
    cyc(0, 0, 1, 0, 8'hEE);
    chk("ovf_flag", int'(stack_ovf), 1);
    chk("ovf_halt", int'(halted), 1);
    chk("ovf_pc", int'(pc), 'h83);
    cyc(0, 1, 0, 0, 8'h11);
    cyc(0, 0, 0, 1, 8'h00);
    free(2);
    chk("halt_pc", int'(pc), 'h83);
    chk("halt_sp", int'(sp), 4);
    do_reset();
    chk("clr_pc", int'(pc), 0);
    chk("clr_flags", int'({halted, stack_ovf, stack_unf, sp}), 0);

    cyc(0, 0, 0, 1, 8'h00);
    chk("unf_flag", int'(stack_unf), 1);
    chk("unf_halt", int'(halted), 1);
    chk("unf_pc", int'(pc), 0);
    do_reset();
    cyc(0, 1, 0, 0, 8'hFF);
    free(1);
    chk("wrap_pc", int'(pc), 0);
    cyc(0, 1, 0, 0, 8'hFF);
    cyc(0, 0, 1, 0, 8'h10);
    cyc(0, 0, 0, 1, 8'h00);
    chk("wrap_ret", int'(pc), 0);

    cyc(0, 0, 1, 0, 8'h44);
    cyc(0, 1, 1, 1, 8'h77);
    chk("prio_pc", int'(pc), 1);
    chk("prio_sp", int'(sp), 0);

    cyc(0, 0, 1, 0, 8'h50);
    call_en = 1'b1; jmp_addr = 8'h60;
    @(posedge clk);
    #2;
    cmp_en = 1'b0;
    res = 1'b1;
    #1;
    chk("async_pc", int'(pc), 0);
    chk("async_sp", int'(sp), 0);
    model_reset();
    call_en = 1'b0;
    @(negedge clk);
    res = 1'b0;
    cmp_en = 1'b1;

    for (int i = 0; i < 3000; i++) begin
      if (m_halt && $urandom_range(0, 7) == 0) begin
        do_reset();
      end else begin
        cyc($urandom_range(0, 7) == 0, $urandom_range(0, 5) == 0,
            $urandom_range(0, 4) == 0, $urandom_range(0, 4) == 0,
            8'($urandom_range(0, 255)));
      end
    end

    cmp_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
